mse_port_master: RTL and testbench

Initiator end of the 8-bit MSE port bus; it drives the bus that the port I/O responder (port0..port9) decodes.
A local requester issues single read/write transactions to one of ten 8-bit ports.
The block serialises each transaction onto the shared bidirectional byte bus with a latch strobe, waits for the responder's ready, and returns read data.
It sits on the host/test-controller side of the MSE connector, clocked by the same bus clock as the responder.

---
 rtl/mse_bus_pkg.sv | 27 ++
 rtl/mse_port_master_if.sv | 29 ++
 rtl/mse_bus_timeout.sv | 31 +++
 rtl/mse_port_master.sv | 169 ++++++++++++++++
 tb/tb_mse_port_master.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mse_bus_pkg.sv
// Shared types and helpers for the MSE port bus (initiator and responder sides).
// Command byte layout: write flag in the MSB, port index in the low nibble.
package mse_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WDATA,
      ST_TURN,
      ST_WAIT_RDY,
      ST_RDATA,
      ST_DONE
   } state_t;

   localparam int CMD_WRITE_BIT     = 7;
   localparam int CMD_PORT_MSB      = 3;
   localparam int NUM_PORTS_DEFAULT = 10;

   function automatic logic [7:0] build_cmd(input logic write, input logic [CMD_PORT_MSB:0] port);
      logic [7:0] cmd;
      cmd                  = 8'h00;
      cmd[CMD_WRITE_BIT]   = write;
      cmd[CMD_PORT_MSB:0]  = port;
      return cmd;
   endfunction

endpackage

// File: rtl/mse_port_master_if.sv
// Request/response and pin-side signals of the MSE port initiator.
// master = the initiator block; slave = requester plus bus responder seen from outside.
interface mse_port_master_if;

   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [3:0] req_port;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic [7:0] bus_dout;
   logic       bus_oe;
   logic [7:0] bus_din;
   logic       bus_le;
   logic       bus_rdy;

   modport master (
      input  req_valid, req_write, req_port, req_wdata, bus_din, bus_rdy,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, bus_dout, bus_oe, bus_le
   );

   modport slave (
      output req_valid, req_write, req_port, req_wdata, bus_din, bus_rdy,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, bus_dout, bus_oe, bus_le
   );

endinterface

// File: rtl/mse_bus_timeout.sv
// Loadable down-counter; expired is high whenever the count sits at zero.
// Priority: reset, clear, load, then decrement (saturating at zero) while enabled.
module mse_bus_timeout #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/mse_port_master.sv
// MSE port bus initiator: serialises one read/write per request, returns data/err on a rsp_valid pulse.
// Latency write 4 / read 5 cycles minimum; req_ready only in IDLE, so one transaction in flight at a time.
module mse_port_master
   import mse_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TURN_CYCLES    = 1,
   parameter int NUM_PORTS      = NUM_PORTS_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   mse_port_master_if.master   mif
);

   localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] TURN_LOAD = 16'(TURN_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;

   logic        wr_q;
   logic [3:0]  port_q;
   logic [7:0]  wdata_q;
   logic [7:0]  rdata_q;
   logic [7:0]  rsp_rdata_q;
   logic        rsp_err_q;

   logic        bad_port;
   logic        fail;
   logic        tmr_clr;
   logic        tmr_load;
   logic [15:0] tmr_val;
   logic        tmr_en;
   logic        tmr_expired;

   assign bad_port = ({28'd0, mif.req_port} >= 32'(NUM_PORTS));
   assign tmr_clr  = (state == ST_IDLE);

   // One counter serves both the turnaround and the ready timeout; the phases never overlap.
   mse_bus_timeout #(.WIDTH(16)) u_timeout (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (tmr_clr),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = 16'd0;
      tmr_en    = 1'b0;
      fail      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mif.req_valid) begin
               if (bad_port) begin
                  state_nxt = ST_DONE;
                  fail      = 1'b1;
               end else begin
                  state_nxt = ST_CMD;
               end
            end
         end
         ST_CMD: begin
            if (wr_q) begin
               state_nxt = ST_WDATA;
            end else begin
               state_nxt = ST_TURN;
               tmr_load  = 1'b1;
               tmr_val   = TURN_LOAD;
            end
         end
         ST_WDATA: begin
            state_nxt = ST_WAIT_RDY;
            tmr_load  = 1'b1;
            tmr_val   = TMO_LOAD;
         end
         ST_TURN: begin
            if (tmr_expired) begin
               state_nxt = ST_WAIT_RDY;
               tmr_load  = 1'b1;
               tmr_val   = TMO_LOAD;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_WAIT_RDY: begin
            // Ready is checked before expiry so a late ack on the last cycle still succeeds.
            if (mif.bus_rdy) begin
               state_nxt = wr_q ? ST_DONE : ST_RDATA;
            end else if (tmr_expired) begin
               state_nxt = ST_DONE;
               fail      = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_RDATA: state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      mif.req_ready = (state == ST_IDLE);
      mif.rsp_valid = (state == ST_DONE);
      mif.rsp_rdata = rsp_rdata_q;
      mif.rsp_err   = rsp_err_q;
      mif.bus_oe    = 1'b0;
      mif.bus_le    = 1'b0;
      mif.bus_dout  = 8'h00;
      case (state)
         ST_CMD: begin
            mif.bus_oe   = 1'b1;
            mif.bus_le   = 1'b1;
            mif.bus_dout = build_cmd(wr_q, port_q);
         end
         ST_WDATA: begin
            mif.bus_oe   = 1'b1;
            mif.bus_dout = wdata_q;
         end
         ST_WAIT_RDY: begin
            if (wr_q) begin
               mif.bus_oe   = 1'b1;
               mif.bus_dout = wdata_q;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q        <= 1'b0;
         port_q      <= 4'd0;
         wdata_q     <= 8'h00;
         rdata_q     <= 8'h00;
         rsp_rdata_q <= 8'h00;
         rsp_err_q   <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && mif.req_valid) begin
            wr_q    <= mif.req_write;
            port_q  <= mif.req_port;
            wdata_q <= mif.req_wdata;
         end
         if ((state == ST_WAIT_RDY) && !wr_q && mif.bus_rdy) begin
            rdata_q <= mif.bus_din;
         end
         // Response fields only move on DONE entry, so they hold between transactions.
         if (state_nxt == ST_DONE) begin
            rsp_err_q   <= fail;
            rsp_rdata_q <= (state == ST_RDATA) ? rdata_q : 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_mse_port_master.sv
// Bench for mse_port_master: scripted requests, a reactive responder model and a response scoreboard.
module tb_mse_port_master;
   import mse_bus_pkg::*;

   localparam int TB_PORTS = 10;

   typedef struct {
      logic       wr;
      logic [7:0] cmd;
      logic [7:0] wdata;
      logic [7:0] din;
      int         rdy_at;
   } rcfg_t;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      int         lat;
   } exp_t;

   logic clk;
   logic rst_n;

   mse_port_master_if mif();

   mse_port_master #(
      .TIMEOUT_CYCLES (16),
      .TURN_CYCLES    (1),
      .NUM_PORTS      (TB_PORTS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mif   (mif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc = 0;
   int    acc_cyc = 0;
   int    last_rsp_cyc = 0;
   int    acc_gap = 0;
   int    rsp_cnt = 0;
   int    rsp_exp_cnt = 0;
   int    bus_act = 0;
   rcfg_t cfg_q[$];
   exp_t  exp_q[$];
   rcfg_t cur;
   logic  busy = 1'b0;
   logic  drv = 1'b0;
   int    k = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sampled on the falling edge, mid-cycle.
   task automatic monitor();
      exp_t e;
      if (rst_n) begin
         if (mif.req_valid && mif.req_ready) begin
            acc_gap = cyc - last_rsp_cyc;
            acc_cyc = cyc;
         end
         if (mif.bus_oe || mif.bus_le) bus_act++;
         if (drv && mif.bus_oe) check("contention", 32'(1), 32'(0));
         if (mif.rsp_valid) begin
            rsp_cnt++;
            last_rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected rsp", 32'(1), 32'(0));
            end else begin
               e = exp_q.pop_front();
               check("rsp_rdata", 32'(mif.rsp_rdata), 32'(e.rdata));
               check("rsp_err", 32'(mif.rsp_err), 32'(e.err));
               check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
            end
         end
      end
   endtask

   // Responder model, updated just after the rising edge for the new cycle.
   task automatic responder();
      int w;
      if (!rst_n) begin
         busy = 1'b0;
         drv  = 1'b0;
         mif.bus_rdy = 1'b0;
         mif.bus_din = 8'hEE;
      end else if (!busy) begin
         drv  = 1'b0;
         mif.bus_rdy = 1'b0;
         mif.bus_din = 8'hEE;
         if (mif.bus_le) begin
            if (cfg_q.size() == 0) begin
               check("unexpected cmd", 32'(1), 32'(0));
            end else begin
               cur  = cfg_q.pop_front();
               busy = 1'b1;
               k    = 0;
               check("cmd byte", 32'(mif.bus_dout), 32'(cur.cmd));
               check("cmd oe", 32'(mif.bus_oe), 32'(1));
            end
         end
      end else if (mif.rsp_valid) begin
         busy = 1'b0;
         drv  = 1'b0;
         mif.bus_rdy = 1'b0;
         mif.bus_din = 8'hEE;
      end else begin
         k++;
         w = k - 2;
         if (k == 1 && cur.wr) begin
            check("wdata byte", 32'(mif.bus_dout), 32'(cur.wdata));
            check("wdata le", 32'(mif.bus_le), 32'(0));
            check("wdata oe", 32'(mif.bus_oe), 32'(1));
         end
         if (k == 1 && !cur.wr) check("turn oe", 32'(mif.bus_oe), 32'(0));
         mif.bus_rdy = (w >= 0) && (w == cur.rdy_at);
         drv = !cur.wr && (w >= 0) && ((cur.rdy_at < 0) || (w <= cur.rdy_at));
         mif.bus_din = drv ? cur.din : 8'hEE;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
      responder();
   endtask

   task automatic issue(input logic wr, input logic [3:0] port, input logic [7:0] wdata,
                        input logic [7:0] din, input int rdy_at, input logic [7:0] e_rdata,
                        input logic e_err, input int e_lat, input logic hold, input logic expect_rsp);
      rcfg_t c;
      exp_t  e;
      int    n;
      if (int'(port) < TB_PORTS) begin
         c.wr     = wr;
         c.cmd    = {wr, 3'b000, port};
         c.wdata  = wdata;
         c.din    = din;
         c.rdy_at = rdy_at;
         cfg_q.push_back(c);
      end
      if (expect_rsp) begin
         e.rdata = e_rdata;
         e.err   = e_err;
         e.lat   = e_lat;
         exp_q.push_back(e);
         rsp_exp_cnt++;
      end
      mif.req_valid = 1'b1;
      mif.req_write = wr;
      mif.req_port  = port;
      mif.req_wdata = wdata;
      n = 0;
      while (!mif.req_ready && n < 100) begin
         tick();
         n++;
      end
      if (!mif.req_ready) check("req_ready wait", 32'(0), 32'(1));
      tick();
      if (!hold) mif.req_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      while (rsp_cnt < rsp_exp_cnt && n < 200) begin
         tick();
         n++;
      end
      check("rsp arrived", 32'(rsp_cnt), 32'(rsp_exp_cnt));
   endtask

   int act0;

   initial begin
      rst_n         = 1'b0;
      mif.req_valid = 1'b0;
      mif.req_write = 1'b0;
      mif.req_port  = 4'd0;
      mif.req_wdata = 8'h00;
      mif.bus_rdy   = 1'b0;
      mif.bus_din   = 8'hEE;
      repeat (3) tick();
      check("rst req_ready", 32'(mif.req_ready), 32'(1));
      check("rst rsp_valid", 32'(mif.rsp_valid), 32'(0));
      check("rst rsp_rdata", 32'(mif.rsp_rdata), 32'(0));
      check("rst rsp_err", 32'(mif.rsp_err), 32'(0));
      check("rst bus_oe", 32'(mif.bus_oe), 32'(0));
      check("rst bus_dout", 32'(mif.bus_dout), 32'(0));
      check("rst bus_le", 32'(mif.bus_le), 32'(0));
      check("rst state", 32'(dut.state), 32'(ST_IDLE));
      rst_n = 1'b1;
      tick();

      // write port 3, ready already high on WAIT entry
      issue(1'b1, 4'd3, 8'hA5, 8'hEE, 0, 8'h00, 1'b0, 4, 1'b0, 1'b1);
      check("ready dropped", 32'(mif.req_ready), 32'(0));
      wait_rsp();

      // read port 7, ready two cycles into WAIT
      issue(1'b0, 4'd7, 8'h00, 8'h3C, 2, 8'h3C, 1'b0, 7, 1'b0, 1'b1);
      wait_rsp();

      // read port 2, no ready: full 16-cycle timeout
      issue(1'b0, 4'd2, 8'h00, 8'h44, -1, 8'h00, 1'b1, 19, 1'b0, 1'b1);
      wait_rsp();

      // ready on the last timeout cycle still succeeds
      issue(1'b0, 4'd2, 8'h00, 8'h5A, 15, 8'h5A, 1'b0, 20, 1'b0, 1'b1);
      wait_rsp();

      // highest legal port, slow write
      issue(1'b1, 4'd9, 8'h6B, 8'hEE, 3, 8'h00, 1'b0, 7, 1'b0, 1'b1);
      wait_rsp();

      // rejected ports never touch the bus
      act0 = bus_act;
      issue(1'b0, 4'd12, 8'h00, 8'hEE, 0, 8'h00, 1'b1, 1, 1'b0, 1'b1);
      wait_rsp();
      check("bad port 12 bus", 32'(bus_act - act0), 32'(0));
      act0 = bus_act;
      issue(1'b1, 4'd10, 8'h12, 8'hEE, 0, 8'h00, 1'b1, 1, 1'b0, 1'b1);
      wait_rsp();
      check("bad port 10 bus", 32'(bus_act - act0), 32'(0));
      check("err holds", 32'(mif.rsp_err), 32'(1));

      // reset while a write sits in WAIT_RDY
      issue(1'b1, 4'd5, 8'h77, 8'hEE, -1, 8'h00, 1'b0, 0, 1'b0, 1'b0);
      repeat (3) tick();
      check("mid-write oe", 32'(mif.bus_oe), 32'(1));
      rst_n = 1'b0;
      tick();
      check("abort bus_oe", 32'(mif.bus_oe), 32'(0));
      check("abort req_ready", 32'(mif.req_ready), 32'(1));
      check("abort rsp_valid", 32'(mif.rsp_valid), 32'(0));
      check("abort state", 32'(dut.state), 32'(ST_IDLE));
      rst_n = 1'b1;
      issue(1'b0, 4'd1, 8'h00, 8'hC3, 0, 8'hC3, 1'b0, 5, 1'b0, 1'b1);
      wait_rsp();

      // back-to-back: write then read with req_valid held
      issue(1'b1, 4'd4, 8'h11, 8'hEE, 0, 8'h00, 1'b0, 4, 1'b1, 1'b1);
      issue(1'b0, 4'd6, 8'h00, 8'h99, 1, 8'h99, 1'b0, 6, 1'b0, 1'b1);
      check("b2b accept gap", 32'(acc_gap), 32'(1));
      wait_rsp();
      repeat (3) tick();

      check("scoreboard empty", 32'(exp_q.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
